seq_checker: RTL
================

SEQ_CHECKER -- requirements
Module: seq_checker

Interface
REQ-001 SHALL have parameter STEP, 1, expected increment (mod 16) between consecutive valid samples.
REQ-002 SHALL have parameter LOCK_LEN, 4, consecutive matching transitions required to lock (legal range 1..15).
REQ-003 SHALL have parameter ERR_W, 8, width of error counter.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port datain  input  4  sample from upstream sequence counter dataout.
REQ-007 SHALL have port valid  input  1  datain qualifier; sample taken only when high.
REQ-008 SHALL have port clr_cnt  input  1  synchronous clear of err_count.
REQ-009 SHALL have port locked  output  1  high while in LOCKED state.
REQ-010 SHALL have port err  output  1  one-cycle pulse per counted mismatch.
REQ-011 SHALL have port err_count  output  ERR_W  saturating count of counted mismatches.
REQ-012 SHALL have port expected  output  4  next expected sample (prev + STEP mod 16).

Function
REQ-013 SHALL implement FSM states HUNT, ACQ, LOCKED; all outputs registered, updated on the edge that samples valid datain (visible the following cycle).
REQ-014 SHALL, in HUNT, on valid: store prev=datain, run=0, go ACQ.
REQ-015 SHALL define match as datain == (prev + STEP) mod 16; 4-bit wrap-around (F->0 for STEP=1) is a match.
REQ-016 SHALL, in ACQ, on valid match: run+1; on reaching LOCK_LEN go LOCKED; on valid mismatch: run=0, stay ACQ, no err, no count.
REQ-017 SHALL, in LOCKED, on valid match: stay; on valid mismatch: err=1 for one cycle, err_count+1 (saturating at all-ones), run=0, go ACQ.
REQ-018 SHALL update prev=datain on every valid sample in ACQ and LOCKED (resync on mismatch).
REQ-019 SHALL hold state, run, prev and all outputs (err=0) while valid low; gaps of any length are transparent.
REQ-020 SHALL drive expected=0 in HUNT, prev+STEP otherwise.
REQ-021 SHALL, on clr_cnt with a simultaneous counted mismatch, give err_count=1; clr_cnt alone gives 0; err pulse unaffected by clr_cnt.

Reset
REQ-022 SHALL, on reset (priority over all inputs, including mid-lock), set state HUNT, run=0, prev=0, locked=0, err=0, err_count=0, expected=0.

Configuration
REQ-023 SHALL, with SEQ_CHECKER_CAPTURE_EN defined, add outputs last_bad[3:0] and last_exp[3:0] loaded with datain and expected on each counted mismatch, reset to 0.
REQ-024 SHALL, without SEQ_CHECKER_CAPTURE_EN, omit those ports and registers; all other behaviour identical.

Structure
REQ-025 SHALL take FSM state enum and 4-bit data width constant from shared package seq_pkg.
REQ-026 SHALL instantiate one sub-module sat_counter (parameter width; inc, clr, reset inputs) for err_count.

Verification (STEP=1, LOCK_LEN=4 unless stated)
REQ-027 SHALL check reset held 2 cycles -> locked=0, err=0, err_count=0, expected=0, state HUNT.
REQ-028 SHALL check valid stream 0,1,2,3,4 -> locked=1 one cycle after sample 4, err never 1.
REQ-029 SHALL check locked stream E,F,0,1 -> locked stays 1, err_count unchanged (wrap).
REQ-030 SHALL check locked stream 5,6,9 -> err one-cycle pulse, err_count=1, locked=0, expected=A; then A,B,C,D -> locked=1.
REQ-031 SHALL check 0,1, valid low 3 cycles with datain=7, then 2,3,4 -> locks, no err.
REQ-032 SHALL check ERR_W=2, 5 counted errors -> err_count=3; clr_cnt with error same cycle -> 1; reset while locked -> all outputs 0.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the sequence checker.
package seq_pkg;

  // Width of the sample stream coming from the upstream sequence counter.
  localparam int DATA_W = 4;

  // Checker FSM states.
  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2
  } seq_state_e;

  // Next value in the sequence, wrapping modulo 2**DATA_W.
  function automatic logic [DATA_W-1:0] seq_next(input logic [DATA_W-1:0] cur,
                                                 input logic [DATA_W-1:0] step);
    seq_next = cur + step;
  endfunction

endpackage

// File: rtl/seq_checker_sat_counter.sv
// Saturating up-counter with synchronous clear.
// A clear that coincides with an increment leaves the count at 1,
// so that event is not lost.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear has priority, an increment stops at all-ones.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      if (inc) begin
        count_d = {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
        count_d = {WIDTH{1'b0}};
      end
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= {WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/seq_checker.sv
// Sequence checker: locks onto a stream that advances by STEP (mod 16)
// on each valid sample and counts mismatches seen while locked.
// Optional capture of the last bad sample / expected value is enabled by
// defining SEQ_CHECKER_CAPTURE_EN.
module seq_checker
  import seq_pkg::*;
#(
  parameter int STEP     = 1,
  parameter int LOCK_LEN = 4,
  parameter int ERR_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] datain,
  input  logic              valid,
  input  logic              clr_cnt,
  output logic              locked,
  output logic              err,
  output logic [ERR_W-1:0]  err_count,
`ifdef SEQ_CHECKER_CAPTURE_EN
  output logic [DATA_W-1:0] last_bad,
  output logic [DATA_W-1:0] last_exp,
`endif
  output logic [DATA_W-1:0] expected
);

  localparam logic [DATA_W-1:0] STEP_C = DATA_W'(STEP);
  localparam logic [3:0]        LOCK_C = 4'(LOCK_LEN);

  seq_state_e        state_q, state_d;
  logic [3:0]        run_q, run_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              locked_q, locked_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] expected_q, expected_d;
  logic              match_s;
  logic              inc_s;

  // Next-state logic: acquire, lock and count mismatches on valid samples.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    prev_d  = prev_q;
    err_d   = 1'b0;
    inc_s   = 1'b0;
    match_s = (datain == seq_next(prev_q, STEP_C));
    if (valid) begin
      case (state_q)
        ST_HUNT: begin
          prev_d  = datain;
          run_d   = 4'd0;
          state_d = ST_ACQ;
        end
        ST_ACQ: begin
          prev_d = datain;
          if (match_s) begin
            run_d = run_q + 4'd1;
            if ((run_q + 4'd1) >= LOCK_C) begin
              state_d = ST_LOCKED;
            end else begin
              state_d = ST_ACQ;
            end
          end else begin
            run_d   = 4'd0;
            state_d = ST_ACQ;
          end
        end
        ST_LOCKED: begin
          prev_d = datain;
          if (match_s) begin
            state_d = ST_LOCKED;
          end else begin
            err_d   = 1'b1;
            inc_s   = 1'b1;
            run_d   = 4'd0;
            state_d = ST_ACQ;
          end
        end
        default: begin
          state_d = ST_HUNT;
          run_d   = 4'd0;
          prev_d  = {DATA_W{1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
    end
    locked_d = (state_d == ST_LOCKED);
    if (state_d == ST_HUNT) begin
      expected_d = {DATA_W{1'b0}};
    end else begin
      expected_d = seq_next(prev_d, STEP_C);
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_HUNT;
      run_q      <= 4'd0;
      prev_q     <= {DATA_W{1'b0}};
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      expected_q <= {DATA_W{1'b0}};
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      prev_q     <= prev_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      expected_q <= expected_d;
    end
  end

  sat_counter #(
    .WIDTH(ERR_W)
  ) u_err_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (inc_s),
    .clr  (clr_cnt),
    .count(err_count)
  );

`ifdef SEQ_CHECKER_CAPTURE_EN
  logic [DATA_W-1:0] last_bad_q;
  logic [DATA_W-1:0] last_exp_q;

  // Capture the offending sample and what was expected on each counted mismatch.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_bad_q <= {DATA_W{1'b0}};
      last_exp_q <= {DATA_W{1'b0}};
    end else if (inc_s) begin
      last_bad_q <= datain;
      last_exp_q <= expected_q;
    end else begin
      last_bad_q <= last_bad_q;
      last_exp_q <= last_exp_q;
    end
  end

  assign last_bad = last_bad_q;
  assign last_exp = last_exp_q;
`endif

  assign locked   = locked_q;
  assign err      = err_q;
  assign expected = expected_q;

endmodule
